// File: rtl/simpleio_v2.sv
// simpleio_v2: LEDs, RGB LEDs, hex byte, switch/key input and a FIFO-buffered 8N1 UART
// on a 16-byte register window. Define SIMPLEIO_V2_LOOPBACK_EN to add the $D loopback control.
module simpleio_v2 #(
  parameter int          LED_WIDTH     = 8,
  parameter int          RX_DEPTH      = 16,
  parameter int          TX_DEPTH      = 16,
  parameter logic [15:0] PRESCALE_INIT = 16'd433
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           Address,
  input  logic [7:0]           DI,
  output logic [7:0]           DO,
  input  logic                 rw,
  input  logic                 cs,
  output logic [LED_WIDTH-1:0] leds,
  output logic [2:0]           rgb1,
  output logic [2:0]           rgb2,
  output logic [7:0]           hex_disp,
  input  logic [3:0]           switches,
  input  logic [3:0]           keys,
  input  logic                 rxd,
  output logic                 txd,
  output logic                 irq
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [2:0]  rgb1_q, rgb1_d, rgb2_q, rgb2_d, irqen_q, irqen_d;
  logic [7:0]  hex_q, hex_d, do_q, do_d;
  logic [15:0] pre_q, pre_d;
  logic        rxovr_q, rxovr_d, frerr_q, frerr_d, txovf_q, txovf_d, irq_q, irq_d;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RX_AW:0]   rx_lvl_q, rx_lvl_d;
  logic [TX_AW:0]   tx_lvl_q, tx_lvl_d;

  logic [1:0]  tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [15:0] tx_tmr_q, tx_tmr_d, tx_div_q, tx_div_d, rx_tmr_q, rx_tmr_d, rx_div_q, rx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic        txd_q, txd_d, rx_s1_q, rx_s2_q, rx_s3_q, rx_in;

  logic       rd_en, wr_en, data_rd, data_wr, rx_full, tx_full, tx_idle;
  logic       rx_pop, rx_push, rx_push_ok, rx_fr_set, tx_pop, tx_push_ok;
  logic [2:0] w1c;
  logic [7:0] status;

`ifdef SIMPLEIO_V2_LOOPBACK_EN
  logic loop_q, loop_d;
  assign rx_in = loop_q ? txd_q : rxd;
  assign txd   = loop_q ? 1'b1 : txd_q;
`else
  assign rx_in = rxd;
  assign txd   = txd_q;
`endif

  assign rd_en      = cs & rw;
  assign wr_en      = cs & ~rw;
  assign data_rd    = rd_en && (Address == 4'h8);
  assign data_wr    = wr_en && (Address == 4'h8);
  assign rx_full    = (rx_lvl_q == RX_FULL);
  assign tx_full    = (tx_lvl_q == TX_FULL);
  assign rx_pop     = data_rd && (rx_lvl_q != '0);
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  // The TX engine pops either from idle or straight out of a finished stop bit.
  assign tx_pop     = (tx_lvl_q != '0) &&
                      ((tx_st_q == S_IDLE) || ((tx_st_q == S_STOP) && (tx_tmr_q == '0)));
  assign tx_push_ok = data_wr && (!tx_full || tx_pop);
  assign tx_idle    = (tx_lvl_q == '0) && (tx_st_q == S_IDLE);
  assign status     = {2'b00, txovf_q, frerr_q, rxovr_q, tx_idle, !tx_full, rx_lvl_q != '0};
  assign w1c        = (wr_en && (Address == 4'h9)) ? DI[5:3] : 3'b000;

  // Bus registers, read mux, sticky flags, FIFO pointers.
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    led_d = led_q; rgb1_d = rgb1_q; rgb2_d = rgb2_q; hex_d = hex_q;
    pre_d = pre_q; irqen_d = irqen_q; do_d = do_q;
`ifdef SIMPLEIO_V2_LOOPBACK_EN
    loop_d = loop_q;
`endif
    if (wr_en) begin
      case (Address)
        4'h0: led_d = DI[LED_WIDTH-1:0];
        4'h1: begin rgb1_d = DI[6:4]; rgb2_d = DI[2:0]; end
        4'h2: hex_d = DI;
        4'hA: pre_d[15:8] = DI;
        4'hB: pre_d[7:0] = DI;
        4'hC: irqen_d = DI[2:0];
`ifdef SIMPLEIO_V2_LOOPBACK_EN
        4'hD: loop_d = DI[0];
`endif
        default: ;
      endcase
    end
    if (rd_en) begin
      case (Address)
        4'h0: do_d = 8'(led_q);
        4'h1: do_d = {1'b0, rgb1_q, 1'b0, rgb2_q};
        4'h2: do_d = hex_q;
        4'h4: do_d = {switches, keys};
        4'h8: do_d = rx_pop ? rx_mem[rx_rp_q] : 8'h00;
        4'h9: do_d = status;
        4'hA: do_d = pre_q[15:8];
        4'hB: do_d = pre_q[7:0];
        4'hC: do_d = {5'b0, irqen_q};
`ifdef SIMPLEIO_V2_LOOPBACK_EN
        4'hD: do_d = {7'b0, loop_q};
`endif
        default: do_d = 8'h00;
      endcase
    end
    // Set beats clear when a new error lands on the W1C cycle.
    rxovr_d = (rxovr_q & ~w1c[0]) | (rx_push && rx_full && !rx_pop);
    frerr_d = (frerr_q & ~w1c[1]) | rx_fr_set;
    txovf_d = (txovf_q & ~w1c[2]) | (data_wr && tx_full && !tx_pop);
    irq_d   = |(irqen_q & {rxovr_q | frerr_q | txovf_q, tx_lvl_q == '0, rx_lvl_q != '0});

    rx_wp_d  = rx_push_ok ? rx_wp_q + RX_AW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop ? rx_rp_q + RX_AW'(1) : rx_rp_q;
    rx_lvl_d = rx_lvl_q + (RX_AW+1)'(rx_push_ok) - (RX_AW+1)'(rx_pop);
    tx_wp_d  = tx_push_ok ? tx_wp_q + TX_AW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop ? tx_rp_q + TX_AW'(1) : tx_rp_q;
    tx_lvl_d = tx_lvl_q + (TX_AW+1)'(tx_push_ok) - (TX_AW+1)'(tx_pop);
  end

  // TX engine; the bit period is latched at each start bit.
  always_comb begin
    tx_st_d  = tx_st_q; tx_div_d = tx_div_q; tx_bit_d = tx_bit_q; tx_sh_d = tx_sh_q;
    tx_tmr_d = (tx_tmr_q != '0) ? tx_tmr_q - 16'd1 : tx_tmr_q;
    case (tx_st_q)
      S_START: if (tx_tmr_q == '0) begin tx_st_d = S_DATA; tx_tmr_d = tx_div_q; tx_bit_d = 3'd0; end
      S_DATA: if (tx_tmr_q == '0) begin
        tx_tmr_d = tx_div_q;
        if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
        else begin tx_bit_d = tx_bit_q + 3'd1; tx_sh_d = tx_sh_q >> 1; end
      end
      S_STOP: if (tx_tmr_q == '0) tx_st_d = S_IDLE;
      default: ;
    endcase
    if (tx_pop) begin
      tx_st_d = S_START; tx_div_d = pre_q; tx_tmr_d = pre_q; tx_sh_d = tx_mem[tx_rp_q];
    end
    case (tx_st_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // RX engine: half-period start check, mid-bit data and stop sampling.
  always_comb begin
    rx_st_d  = rx_st_q; rx_div_d = rx_div_q; rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q;
    rx_tmr_d = (rx_tmr_q != '0) ? rx_tmr_q - 16'd1 : rx_tmr_q;
    rx_push  = 1'b0;
    rx_fr_set = 1'b0;
    case (rx_st_q)
      S_IDLE: if (rx_s3_q && !rx_s2_q) begin
        rx_st_d = S_START; rx_div_d = pre_q; rx_tmr_d = pre_q >> 1;
      end
      S_START: if (rx_tmr_q == '0) begin
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        rx_tmr_d = rx_div_q; rx_bit_d = 3'd0;
      end
      S_DATA: if (rx_tmr_q == '0) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_tmr_d = rx_div_q;
        if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      default: if (rx_tmr_q == '0) begin
        rx_st_d = S_IDLE; rx_push = rx_s2_q; rx_fr_set = !rx_s2_q;
      end
    endcase
  end

  // NOTE: FIFO storage is not reset; the reset pointers/levels guarantee stale words are never read.
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wp_q] <= rx_sh_q;
    if (tx_push_ok) tx_mem[tx_wp_q] <= DI;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0; rgb1_q <= '0; rgb2_q <= '0; hex_q <= '0; do_q <= '0;
      pre_q <= PRESCALE_INIT; irqen_q <= '0; irq_q <= 1'b0;
      rxovr_q <= 1'b0; frerr_q <= 1'b0; txovf_q <= 1'b0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_lvl_q <= '0;
      tx_wp_q <= '0; tx_rp_q <= '0; tx_lvl_q <= '0;
      tx_st_q <= S_IDLE; tx_tmr_q <= '0; tx_div_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0;
      rx_st_q <= S_IDLE; rx_tmr_q <= '0; rx_div_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
      txd_q <= 1'b1; rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
`ifdef SIMPLEIO_V2_LOOPBACK_EN
      loop_q <= 1'b0;
`endif
    end else begin
      led_q <= led_d; rgb1_q <= rgb1_d; rgb2_q <= rgb2_d; hex_q <= hex_d; do_q <= do_d;
      pre_q <= pre_d; irqen_q <= irqen_d; irq_q <= irq_d;
      rxovr_q <= rxovr_d; frerr_q <= frerr_d; txovf_q <= txovf_d;
      rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d; rx_lvl_q <= rx_lvl_d;
      tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; tx_lvl_q <= tx_lvl_d;
      tx_st_q <= tx_st_d; tx_tmr_q <= tx_tmr_d; tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
      rx_st_q <= rx_st_d; rx_tmr_q <= rx_tmr_d; rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      txd_q <= txd_d; rx_s1_q <= rx_in; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
`ifdef SIMPLEIO_V2_LOOPBACK_EN
      loop_q <= loop_d;
`endif
    end
  end

  assign leds     = ~led_q;
  assign rgb1     = ~rgb1_q;
  assign rgb2     = ~rgb2_q;
  assign hex_disp = hex_q;
  assign DO       = do_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_simpleio_v2.sv
// Scoreboard bench for simpleio_v2: reads push expected bytes, a monitor compares DO a cycle later.
// Directed checks cover reset, LED/RGB/hex, TX framing, RX overflow, framing error, IRQ and loopback.
module tb_simpleio_v2;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Address;
  logic [7:0] DI, DO;
  logic       rw, cs;
  logic [7:0] leds;
  logic [2:0] rgb1, rgb2;
  logic [7:0] hex_disp;
  logic [3:0] switches, keys;
  logic       rxd, txd, irq;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  logic        rd_seen = 1'b0;

  simpleio_v2 dut (
    .clk(clk), .rst(rst), .Address(Address), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .leds(leds), .rgb1(rgb1), .rgb2(rgb2), .hex_disp(hex_disp),
    .switches(switches), .keys(keys), .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: DO is valid one cycle after a read strobe.
  always @(posedge clk) rd_seen <= cs && rw;
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL read_unexpected: got %h expected none", DO);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("read[%h]", mon_e[11:8]), 16'(DO), 16'(mon_e[7:0]));
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; Address = a; DI = d;
    @(negedge clk); cs = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e);
    cs = 1'b1; rw = 1'b1; Address = a; exp_q.push_back({a, e});
    @(negedge clk); cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame at 4 clocks per bit, then 4 idle clocks.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (4) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Wait (bounded) for the start bit, then check each bit holds for exactly 4 clocks.
  task automatic expect_tx(input logic [7:0] b);
    logic [9:0] f;
    logic [3:0] smp;
    int w;
    f = {1'b1, b, 1'b0};
    w = 0;
    while (txd !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    check("tx_start_found", 16'(w < 100), 16'd1);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) begin smp[j] = txd; @(negedge clk); end
      check($sformatf("tx_bit%0d", i), 16'(smp), 16'({4{f[i]}}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic hi_ok;
    rst = 1'b1; cs = 1'b0; rw = 1'b1; Address = 4'h0; DI = 8'h00; rxd = 1'b1;
    switches = 4'hA; keys = 4'h5;
    idle(3);
    rst = 1'b0;
    check("rst_leds", 16'(leds), 16'h00FF);
    check("rst_rgb", 16'({rgb1, rgb2}), 16'h003F);
    check("rst_hex", 16'(hex_disp), 16'h0000);
    check("rst_do", 16'(DO), 16'h0000);
    check("rst_txd", 16'(txd), 16'h0001);
    check("rst_irq", 16'(irq), 16'h0000);
    rd(4'h0, 8'h00); rd(4'h1, 8'h00); rd(4'hA, 8'h01); rd(4'hB, 8'hB1); rd(4'h9, 8'h06);
    rd(4'h4, 8'hA5); rd(4'h3, 8'h00);

    // LED / RGB / hex
    wr(4'h0, 8'hA5); wr(4'h1, 8'h52); wr(4'h2, 8'h3C);
    check("leds_pins", 16'(leds), 16'h005A);
    check("rgb1_pins", 16'(rgb1), 16'h0002);
    check("rgb2_pins", 16'(rgb2), 16'h0005);
    check("hex_pins", 16'(hex_disp), 16'h003C);
    rd(4'h0, 8'hA5); rd(4'h1, 8'h52); rd(4'h2, 8'h3C);

    // TX frame at prescaler 3
    wr(4'hA, 8'h00); wr(4'hB, 8'h03); rd(4'hA, 8'h00); rd(4'hB, 8'h03);
    wr(4'h8, 8'h55);
    expect_tx(8'h55);
    rd(4'h9, 8'h06);

    // TX-empty interrupt and busy status
    wr(4'hC, 8'h02); rd(4'hC, 8'h02);
    check("irq_txempty", 16'(irq), 16'h0001);
    wr(4'h8, 8'hFF); rd(4'h9, 8'h02);
    idle(60); rd(4'h9, 8'h06);
    wr(4'hC, 8'h00); idle(2);
    check("irq_off", 16'(irq), 16'h0000);

    // TX FIFO overflow: 1 popped at once + 16 queued + 1 dropped
    for (int i = 0; i < 18; i++) wr(4'h8, 8'(i));
    rd(4'h9, 8'h20);
    idle(760);
    rd(4'h9, 8'h26);
    wr(4'h9, 8'h20); rd(4'h9, 8'h06);

    // RX glitch reject, then RX_DEPTH+1 frames
    rxd = 1'b0; idle(1); rxd = 1'b1; idle(12);
    rd(4'h9, 8'h06);
    for (int i = 0; i < 17; i++) send_rx(8'(i), 1'b1);
    rd(4'h9, 8'h0F);
    for (int i = 0; i < 16; i++) rd(4'h8, 8'(i));
    rd(4'h9, 8'h0E);
    rd(4'h8, 8'h00);
    wr(4'h9, 8'h08); rd(4'h9, 8'h06);

    // Framing error with error interrupt enabled
    wr(4'hC, 8'h04); idle(2);
    check("irq_pre_frerr", 16'(irq), 16'h0000);
    send_rx(8'hAA, 1'b0);
    check("irq_frerr", 16'(irq), 16'h0001);
    rd(4'h9, 8'h16);
    rd(4'h8, 8'h00);
    wr(4'h9, 8'h10); idle(2);
    check("irq_frerr_clr", 16'(irq), 16'h0000);
    rd(4'h9, 8'h06);
    wr(4'hC, 8'h00);

`ifdef SIMPLEIO_V2_LOOPBACK_EN
    wr(4'hD, 8'h01); rd(4'hD, 8'h01);
    wr(4'h8, 8'hC3);
    hi_ok = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (txd !== 1'b1) hi_ok = 1'b0;
      @(negedge clk);
    end
    check("loop_txd_high", 16'(hi_ok), 16'h0001);
    rd(4'h9, 8'h07);
    rd(4'h8, 8'hC3);
    wr(4'hD, 8'h00);
`else
    hi_ok = 1'b1;
    wr(4'hD, 8'hFF); rd(4'hD, 8'h00);
    check("noloop_txd_idle", 16'(txd & hi_ok), 16'h0001);
`endif

    idle(4);
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL reads_outstanding: got %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
